// File: rtl/ps2_cmd_sched.sv
// ps2_cmd_sched: two-requester PS/2 command scheduler with ACK, resend and timeout.
// Optional macro PS2_SCHED_RX_FILTER_EN hides ACK/RESEND bytes consumed while waiting.
module ps2_cmd_sched #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic [7:0] i_cmd0,
    input  logic [7:0] i_cmd1,
    input  logic [7:0] i_arg0,
    input  logic [7:0] i_arg1,
    input  logic       i_has_arg0,
    input  logic       i_has_arg1,
    output logic [1:0] o_gnt,
    output logic [1:0] o_done,
    output logic [1:0] o_err,
    output logic       o_tx_vld,
    output logic [7:0] o_tx_dat,
    input  logic       i_tx_rdy,
    input  logic       i_rx_vld,
    input  logic [7:0] i_rx_dat,
    output logic       o_rx_vld,
    output logic [7:0] o_rx_dat,
    output logic       o_busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [7:0] ACK    = 8'hFA;
    localparam logic [7:0] RESEND = 8'hFE;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        WAIT_CMD,
        SEND_ARG,
        WAIT_ARG
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      cmd_q;
    logic [7:0]      arg_q;
    logic            has_arg_q;
    logic            owner;
    logic            rr;
    logic [TW-1:0]   tmo_cnt;
    logic [RW-1:0]   retry;
    logic            pick;
    logic            grant;
    logic            in_wait;
    logic            is_ack;
    logic            is_nak;
    logic            tmo_hit;
    logic            retry_max;
    logic            tx_hs;
    logic            finish_ok;
    logic            finish_err;
    logic            rx_drop;

    // rr names the requester that wins a tie; the other one was granted last
    assign pick      = i_req[rr] ? rr : ~rr;
    assign grant     = (state == IDLE) && (|i_req);
    assign in_wait   = (state == WAIT_CMD) || (state == WAIT_ARG);
    assign is_ack    = in_wait && i_rx_vld && (i_rx_dat == ACK);
    assign is_nak    = in_wait && i_rx_vld && (i_rx_dat == RESEND);
    assign tmo_hit   = tmo_cnt == TW'(TIMEOUT_CYC - 1);
    assign retry_max = retry == RW'(MAX_RETRY);
    assign tx_hs     = o_tx_vld && i_tx_rdy;

`ifdef PS2_SCHED_RX_FILTER_EN
    assign rx_drop = in_wait && ((i_rx_dat == ACK) || (i_rx_dat == RESEND));
`else
    assign rx_drop = 1'b0;
`endif

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state; ACK is tested before timeout so it wins a tie
    always_comb begin
        state_nxt  = state;
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant) state_nxt = SEND_CMD;
            end
            SEND_CMD: begin
                if (i_tx_rdy) state_nxt = WAIT_CMD;
            end
            SEND_ARG: begin
                if (i_tx_rdy) state_nxt = WAIT_ARG;
            end
            WAIT_CMD: begin
                if (is_ack) begin
                    if (has_arg_q) begin
                        state_nxt = SEND_ARG;
                    end else begin
                        state_nxt = IDLE;
                        finish_ok = 1'b1;
                    end
                end else if (is_nak && !retry_max) begin
                    state_nxt = SEND_CMD;
                end else if (is_nak || tmo_hit) begin
                    state_nxt  = IDLE;
                    finish_err = 1'b1;
                end
            end
            WAIT_ARG: begin
                if (is_ack) begin
                    state_nxt = IDLE;
                    finish_ok = 1'b1;
                end else if (is_nak && !retry_max) begin
                    state_nxt = SEND_ARG;
                end else if (is_nak || tmo_hit) begin
                    state_nxt  = IDLE;
                    finish_err = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // transmitter and status outputs decoded from state
    always_comb begin
        o_busy   = state != IDLE;
        o_tx_vld = (state == SEND_CMD) || (state == SEND_ARG);
        o_tx_dat = 8'h00;
        if (state == SEND_CMD) o_tx_dat = cmd_q;
        if (state == SEND_ARG) o_tx_dat = arg_q;
    end

    // grant latch, retry/timeout counters and completion pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_gnt     <= 2'b00;
            o_done    <= 2'b00;
            o_err     <= 2'b00;
            cmd_q     <= 8'h00;
            arg_q     <= 8'h00;
            has_arg_q <= 1'b0;
            owner     <= 1'b0;
            rr        <= 1'b0;
            tmo_cnt   <= '0;
            retry     <= '0;
        end else begin
            o_gnt  <= 2'b00;
            o_done <= {owner & finish_ok, ~owner & finish_ok};
            o_err  <= {owner & finish_err, ~owner & finish_err};
            if (grant) begin
                o_gnt     <= pick ? 2'b10 : 2'b01;
                owner     <= pick;
                rr        <= ~pick;
                cmd_q     <= pick ? i_cmd1 : i_cmd0;
                arg_q     <= pick ? i_arg1 : i_arg0;
                has_arg_q <= pick ? i_has_arg1 : i_has_arg0;
                retry     <= '0;
            end
            if (tx_hs || !in_wait) tmo_cnt <= '0;
            else                   tmo_cnt <= tmo_cnt + 1'b1;
            if (is_ack)                     retry <= '0;
            else if (is_nak && !retry_max)  retry <= retry + 1'b1;
        end
    end

    // receiver bytes forwarded one cycle later
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rx_vld <= 1'b0;
            o_rx_dat <= 8'h00;
        end else begin
            o_rx_vld <= i_rx_vld && !rx_drop;
            if (i_rx_vld) o_rx_dat <= i_rx_dat;
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sched.sv
// tb_ps2_cmd_sched: directed and randomized checks of ps2_cmd_sched.
// Expected traffic is derived from response scripts, not from DUT state.
module tb_ps2_cmd_sched;

    localparam int T  = 100;
    localparam int MR = 3;
`ifdef PS2_SCHED_RX_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] cmd0, cmd1, arg0, arg1;
    logic       ha0, ha1;
    logic [1:0] gnt, done, err;
    logic       tx_vld;
    logic [7:0] tx_dat;
    logic       tx_rdy;
    logic       rx_vld;
    logic [7:0] rx_dat;
    logic       orx_vld;
    logic [7:0] orx_dat;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_gnt = 1;
    logic [7:0] pc [2];
    logic [7:0] pa [2];
    bit         ph [2];

    ps2_cmd_sched #(.TIMEOUT_CYC(T), .MAX_RETRY(MR)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_cmd0(cmd0), .i_cmd1(cmd1), .i_arg0(arg0), .i_arg1(arg1),
        .i_has_arg0(ha0), .i_has_arg1(ha1),
        .o_gnt(gnt), .o_done(done), .o_err(err),
        .o_tx_vld(tx_vld), .o_tx_dat(tx_dat), .i_tx_rdy(tx_rdy),
        .i_rx_vld(rx_vld), .i_rx_dat(rx_dat),
        .o_rx_vld(orx_vld), .o_rx_dat(orx_dat), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic int rr_pick(input logic [1:0] r);
        int pref;
        pref = 1 - last_gnt;
        return r[pref] ? pref : 1 - pref;
    endfunction

    task automatic set_req(input int w, input logic [7:0] c, input logic [7:0] a, input bit h);
        pc[w] = c;
        pa[w] = a;
        ph[w] = h;
        if (w == 0) begin cmd0 = c; arg0 = a; ha0 = h; end
        else        begin cmd1 = c; arg1 = a; ha1 = h; end
        req[w] = 1'b1;
    endtask

    task automatic strobe(input logic [7:0] d);
        rx_vld = 1'b1;
        rx_dat = d;
        step();
        rx_vld = 1'b0;
        rx_dat = 8'h00;
    endtask

    task automatic wait_gnt(input int w);
        int n;
        n = 0;
        step();
        n++;
        chk("pulse_len", {done, err}, 4'b0000);
        while (gnt == 2'b00 && n < 40) begin
            step();
            n++;
        end
        chk("gnt", gnt, oh(w));
        chk("gnt_lat", n, 1);
        last_gnt = w;
        req[w] = 1'b0;
        if (w == 0) begin cmd0 = ~pc[0]; arg0 = ~pa[0]; ha0 = ~ph[0]; end
        else        begin cmd1 = ~pc[1]; arg1 = ~pa[1]; ha1 = ~ph[1]; end
    endtask

    task automatic serve(input int w, input int nc, input int na, input bit tmo);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        bit   ok_cmd, exp_done, fin, phase;
        int   sent, budget, hs_cyc, dec_cyc, lim, n;
        logic [7:0] b, r;
        ok_cmd = (nc <= MR) && !tmo;
        for (int i = 0; i <= ((nc > MR) ? MR : nc); i++) exp_q.push_back(pc[w]);
        if (ok_cmd && ph[w])
            for (int i = 0; i <= ((na > MR) ? MR : na); i++) exp_q.push_back(pa[w]);
        exp_done = ok_cmd && (!ph[w] || na <= MR);
        fin = 0; phase = 0; sent = 0; budget = 0; hs_cyc = 0; dec_cyc = 0;
        while (!fin && budget < 2000) begin
            budget++;
            if (done != 2'b00 || err != 2'b00) begin
                fin = 1;
            end else if (tx_vld) begin
                b = tx_dat;
                repeat ($urandom_range(0, 2)) begin
                    step();
                    chk("tx_hold", {tx_vld, tx_dat}, {1'b1, b});
                end
                tx_rdy = 1'b1;
                step();
                tx_rdy = 1'b0;
                got_q.push_back(b);
                hs_cyc = cyc;
                chk("tx_drop", tx_vld, 0);
                if (!tmo) begin
                    repeat ($urandom_range(0, 3)) step();
                    if ($urandom_range(0, 1) == 1) begin
                        strobe(8'h1C);
                        chk("scan_fwd", {orx_vld, orx_dat}, {1'b1, 8'h1C});
                        chk("scan_keep", {busy, tx_vld}, 2'b10);
                    end
                    lim = phase ? na : nc;
                    r = (sent < lim) ? 8'hFE : 8'hFA;
                    strobe(r);
                    dec_cyc = cyc;
                    chk("resp_fwd", orx_vld, {31'd0, !FILT});
                    if (r == 8'hFE) sent++;
                    else begin sent = 0; phase = 1; end
                end
            end else begin
                step();
            end
        end
        chk("finished", fin, 1);
        chk("done", done, exp_done ? oh(w) : 2'b00);
        chk("err", err, exp_done ? 2'b00 : oh(w));
        chk("idle", busy, 0);
        chk("pulse_cyc", cyc, tmo ? hs_cyc + T : dec_cyc);
        chk("tx_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("tx_byte", got_q[i], exp_q[i]);
    endtask

    initial begin
        int w, nc, na, hs;
        rst = 1'b1; req = 2'b00; tx_rdy = 1'b0; rx_vld = 1'b0; rx_dat = 8'h00;
        cmd0 = 8'h00; cmd1 = 8'h00; arg0 = 8'h00; arg1 = 8'h00; ha0 = 1'b0; ha1 = 1'b0;
        repeat (2) step();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_tx", {tx_vld, tx_dat}, 0);
        chk("rst_rx", {orx_vld, orx_dat}, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // set LEDs: command plus argument, both acknowledged
        set_req(0, 8'hED, 8'h07, 1'b1);
        wait_gnt(rr_pick(req));
        serve(0, 0, 0, 0);

        // simultaneous requests after reset, then requester 0 asks again
        rst = 1'b1; step(); rst = 1'b0; last_gnt = 1;
        set_req(0, 8'hF2, 8'h00, 1'b0);
        set_req(1, 8'hF3, 8'h2A, 1'b1);
        wait_gnt(rr_pick(req));
        serve(0, 0, 0, 0);
        set_req(0, 8'hF6, 8'h00, 1'b0);
        wait_gnt(rr_pick(req));
        serve(1, 1, 2, 0);
        wait_gnt(rr_pick(req));
        serve(0, 0, 0, 0);

        // resend limit: three resends succeed, four abort
        set_req(1, 8'hF4, 8'h00, 1'b0);
        wait_gnt(rr_pick(req));
        serve(1, 3, 0, 0);
        set_req(1, 8'hF4, 8'h00, 1'b0);
        wait_gnt(rr_pick(req));
        serve(1, 4, 0, 0);

        // no response at all
        set_req(0, 8'hFF, 8'h00, 1'b0);
        wait_gnt(rr_pick(req));
        serve(0, 0, 0, 1);

        // randomized sequences
        for (int k = 0; k < 10; k++) begin
            w  = $urandom_range(0, 1);
            nc = $urandom_range(0, 4);
            na = $urandom_range(0, 4);
            set_req(w, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
            wait_gnt(rr_pick(req));
            serve(w, nc, na, 0);
        end

        // ACK arriving in the very cycle the timeout expires
        set_req(0, 8'hF5, 8'h00, 1'b0);
        wait_gnt(rr_pick(req));
        tx_rdy = 1'b1; step(); tx_rdy = 1'b0;
        hs = cyc;
        repeat (T - 1) step();
        strobe(8'hFA);
        chk("tie_done", done, 2'b01);
        chk("tie_err", err, 2'b00);
        chk("tie_cyc", cyc, hs + T);

        // reset while waiting for the argument ACK
        set_req(1, 8'hF3, 8'h0A, 1'b1);
        wait_gnt(rr_pick(req));
        tx_rdy = 1'b1; step(); tx_rdy = 1'b0;
        strobe(8'hFA);
        chk("arg_send", {tx_vld, tx_dat}, {1'b1, 8'h0A});
        tx_rdy = 1'b1; step(); tx_rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_pulses", {gnt, done, err}, 0);
        chk("mid_rst_tx", {tx_vld, tx_dat}, 0);
        chk("mid_rst_rx", {orx_vld, orx_dat}, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (3) begin
            step();
            chk("post_rst_quiet", {done, err, busy}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_sched.md
PS2_CMD_SCHED -- requirements
Module: ps2_cmd_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000000: ACK wait limit in i_clk cycles (20 ms at 50 MHz).
REQ-002 SHALL have parameter MAX_RETRY, default 3: resends allowed per byte after 0xFE.
REQ-003 SHALL have port i_clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port i_req  in  2  per-requester command request, level, held until o_gnt.
REQ-006 SHALL have ports i_cmd0/i_cmd1  in  8 each  command byte of requester 0/1.
REQ-007 SHALL have ports i_arg0/i_arg1  in  8 each  argument byte of requester 0/1.
REQ-008 SHALL have ports i_has_arg0/i_has_arg1  in  1 each  argument byte follows command.
REQ-009 SHALL have port o_gnt  out  2  one-hot 1-cycle pulse: request accepted, inputs latched.
REQ-010 SHALL have port o_done  out  2  1-cycle pulse: sequence completed with ACK.
REQ-011 SHALL have port o_err  out  2  1-cycle pulse: sequence aborted (timeout or retries exhausted).
REQ-012 SHALL have ports o_tx_vld  out  1 / o_tx_dat  out  8  byte to PS/2 host-to-device transmitter.
REQ-013 SHALL have port i_tx_rdy  in  1  transmitter idle; byte taken when o_tx_vld and i_tx_rdy both high.
REQ-014 SHALL have ports i_rx_vld  in  1 / i_rx_dat  in  8  byte from PS/2 device-to-host receiver, 1-cycle strobe.
REQ-015 SHALL have ports o_rx_vld  out  1 / o_rx_dat  out  8  received bytes forwarded to application.
REQ-016 SHALL have port o_busy  out  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, SEND_CMD, WAIT_CMD, SEND_ARG, WAIT_ARG.
REQ-018 IDLE, i_req!=0: SHALL pick requester round-robin (last-granted gets lower priority; after reset requester 0 first), next cycle pulse o_gnt, latch cmd/arg/has_arg, enter SEND_CMD.
REQ-019 SEND_CMD/SEND_ARG SHALL drive o_tx_vld=1, o_tx_dat=latched byte; on handshake cycle go to WAIT_CMD/WAIT_ARG, o_tx_vld low next cycle.
REQ-020 No timeout SHALL apply in SEND states; o_tx_vld held until i_tx_rdy.
REQ-021 WAIT states: timeout counter SHALL clear on handshake, increment each cycle, abort when it reaches TIMEOUT_CYC.
REQ-022 WAIT_CMD, rx 0xFA: SHALL enter SEND_ARG if has_arg, else pulse o_done and enter IDLE.
REQ-023 WAIT_ARG, rx 0xFA: SHALL pulse o_done for granted requester, enter IDLE.
REQ-024 WAIT state, rx 0xFE: SHALL increment retry count and return to the matching SEND state with same byte; if count already equals MAX_RETRY, SHALL abort.
REQ-025 Retry count SHALL clear at grant and on each ACK (per byte).
REQ-026 Abort SHALL pulse o_err for the granted requester, enter IDLE; o_done not pulsed.
REQ-027 Any other rx byte in WAIT states SHALL not change state or counters.
REQ-028 o_rx_vld/o_rx_dat SHALL register i_rx_vld/i_rx_dat with 1-cycle latency, subject to REQ-035.
REQ-029 ACK and timeout in same cycle: ACK SHALL win.
REQ-030 o_done/o_err SHALL pulse in the cycle after the deciding event; new grant no earlier than the cycle after that.
REQ-031 Requests arriving while busy SHALL wait; no request lost while i_req held.

Reset
REQ-032 With i_rst high at a clock edge: state IDLE, o_gnt=0, o_done=0, o_err=0, o_tx_vld=0, o_tx_dat=0, o_rx_vld=0, o_rx_dat=0, o_busy=0, counters 0, round-robin pointer to requester 0.
REQ-033 Reset mid-sequence SHALL abandon it without o_done or o_err pulse.

Configuration
REQ-034 Macro PS2_SCHED_RX_FILTER_EN SHALL select rx filtering.
REQ-035 Defined: 0xFA/0xFE received in WAIT states SHALL be consumed (o_rx_vld stays 0); all other bytes forwarded. Undefined: every rx byte forwarded; internal handling unchanged.

Verification
REQ-036 req0 cmd 0xED arg 0x07, i_tx_rdy=1, rx 0xFA after each byte -> o_tx_dat 0xED then 0x07, one o_done[0] pulse.
REQ-037 req0 and req1 same cycle after reset -> gnt[0] first, gnt[1] after done[0]; repeat -> gnt[1] first.
REQ-038 cmd 0xF4 no arg, rx 0xFE x3 then 0xFA -> 4 transmissions of 0xF4, done pulse; 0xFE x4 -> err pulse, 4 transmissions.
REQ-039 cmd 0xFF, no rx -> o_err exactly TIMEOUT_CYC (set 100 on bench) cycles after handshake.
REQ-040 Scan byte 0x1C during WAIT_CMD -> forwarded, state kept; 0xFA forwarded only with macro undefined.
REQ-041 i_rst high in WAIT_ARG -> all outputs 0 next cycle, no done/err pulse.
